// File: rtl/me_pkg.sv
// Shared definitions for the block-matching motion search: FSM states,
// default geometry and the width helper used to size ports.
package me_pkg;

    localparam int ME_BLK_DEF    = 16;
    localparam int ME_RANGE_DEF  = 8;
    localparam int ME_PIX_W_DEF  = 8;
    localparam int ME_NUM_PE_DEF = 4;
    localparam int ME_DIST_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_CMP,
        ST_DONE
    } me_state_e;

    function automatic int me_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sad_pe.sv
// One SAD lane: absolute pixel difference folded into a saturating
// accumulator that restarts on the first pixel of each candidate group.
module sad_pe #(
    parameter int PIX_W  = 8,
    parameter int DIST_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              valid_i,
    input  logic              clear_i,
    input  logic [PIX_W-1:0]  ref_i,
    input  logic [PIX_W-1:0]  srch_i,
    output logic [DIST_W-1:0] acc_o
);

    logic [DIST_W-1:0] acc_q;
    logic [DIST_W-1:0] acc_d;
    logic [DIST_W-1:0] accBase;
    logic [PIX_W-1:0]  absDiff;
    logic [DIST_W:0]   accSum;

    // The extra sum bit catches overflow so the distortion pins at all-ones.
    always_comb begin
        absDiff = (ref_i > srch_i) ? (ref_i - srch_i) : (srch_i - ref_i);
        accBase = clear_i ? '0 : acc_q;
        accSum  = {1'b0, accBase} + (DIST_W+1)'(absDiff);
        acc_d   = acc_q;
        if (valid_i) begin
            acc_d = accSum[DIST_W] ? '1 : accSum[DIST_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/motion_search.sv
// Full-search SAD motion estimator evaluating NUM_PE horizontal candidates per pass.
// Define ME_EARLY_TERM_EN to cut a pass short once no lane can beat the best.
module motion_search
    import me_pkg::*;
#(
    parameter int  BLK    = ME_BLK_DEF,
    parameter int  RANGE  = ME_RANGE_DEF,
    parameter int  PIX_W  = ME_PIX_W_DEF,
    parameter int  NUM_PE = ME_NUM_PE_DEF,
    parameter int  DIST_W = ME_DIST_W_DEF,
    localparam int SW     = BLK + 2*RANGE,
    localparam int MV_W   = me_clog2(RANGE) + 1,
    localparam int RA_W   = me_clog2(BLK*BLK),
    localparam int SA_W   = me_clog2(SW*SW)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    ref_rd,
    output logic [RA_W-1:0]         ref_addr,
    input  logic [PIX_W-1:0]        ref_data,
    output logic                    srch_rd,
    output logic [SA_W-1:0]         srch_addr,
    input  logic [NUM_PE*PIX_W-1:0] srch_data,
    output logic [DIST_W-1:0]       best_dist,
    output logic [MV_W-1:0]         mv_x,
    output logic [MV_W-1:0]         mv_y
);

    localparam int            LOG_BLK   = me_clog2(BLK);
    localparam logic [RA_W-1:0] LAST_PIX  = RA_W'(BLK*BLK - 1);
    localparam logic [RA_W-1:0] LAST_LANE = RA_W'(NUM_PE - 1);
    localparam logic [MV_W-1:0] LAST_DY   = MV_W'(2*RANGE - 1);
    localparam logic [MV_W-1:0] LAST_DX0  = MV_W'(2*RANGE - NUM_PE);

    me_state_e         state_q, state_d;
    logic [RA_W-1:0]   cnt_q, cnt_d;
    logic [MV_W-1:0]   dyOff_q, dyOff_d;
    logic [MV_W-1:0]   dx0Off_q, dx0Off_d;
    logic              pixValid_q, pixValid_d;
    logic              pixFirst_q, pixFirst_d;
    logic              haveBest_q, haveBest_d;
    logic [DIST_W-1:0] bestDist_q, bestDist_d;
    logic [MV_W-1:0]   mvX_q, mvX_d;
    logic [MV_W-1:0]   mvY_q, mvY_d;

    logic [DIST_W-1:0] acc [NUM_PE];
    logic [DIST_W-1:0] selAcc;
    logic [SA_W-1:0]   pixRow;
    logic [SA_W-1:0]   pixCol;
    logic              allGe;

    for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
        sad_pe #(
            .PIX_W  (PIX_W),
            .DIST_W (DIST_W)
        ) u_pe (
            .clock   (clock),
            .reset_n (reset_n),
            .valid_i (pixValid_q),
            .clear_i (pixFirst_q),
            .ref_i   (ref_data),
            .srch_i  (srch_data[k*PIX_W +: PIX_W]),
            .acc_o   (acc[k])
        );
    end

    always_comb begin
        selAcc = acc[0];
        for (int k = 0; k < NUM_PE; k++) begin
            if (cnt_q == RA_W'(k)) begin
                selAcc = acc[k];
            end
        end
    end

`ifdef ME_EARLY_TERM_EN
    // Accumulators only reflect the current group from the third RUN cycle on.
    always_comb begin
        allGe = haveBest_q && (cnt_q > RA_W'(1));
        for (int k = 0; k < NUM_PE; k++) begin
            if (acc[k] < bestDist_q) begin
                allGe = 1'b0;
            end
        end
    end
`else
    assign allGe = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dyOff_d    = dyOff_q;
        dx0Off_d   = dx0Off_q;
        haveBest_d = haveBest_q;
        bestDist_d = bestDist_q;
        mvX_d      = mvX_q;
        mvY_d      = mvY_q;
        pixValid_d = (state_q == ST_RUN) && !allGe;
        pixFirst_d = (state_q == ST_RUN) && (cnt_q == '0);
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        ref_rd     = (state_q == ST_RUN);
        srch_rd    = (state_q == ST_RUN);
        pixRow     = SA_W'(cnt_q[RA_W-1:LOG_BLK]);
        pixCol     = SA_W'(cnt_q[LOG_BLK-1:0]);
        ref_addr   = ref_rd ? cnt_q : '0;
        srch_addr  = srch_rd ? ((pixRow + SA_W'(dyOff_q)) * SA_W'(SW) + pixCol + SA_W'(dx0Off_q)) : '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    dyOff_d    = '0;
                    dx0Off_d   = '0;
                    haveBest_d = 1'b0;
                    bestDist_d = '1;
                    mvX_d      = '0;
                    mvY_d      = '0;
                end
            end
            ST_RUN: begin
                if (allGe || (cnt_q == LAST_PIX)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + RA_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == RA_W'(1)) begin
                    state_d = ST_CMP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + RA_W'(1);
                end
            end
            ST_CMP: begin
                // The very first lane seeds the best so a saturated search still reports a vector.
                if (!haveBest_q || (selAcc < bestDist_q)) begin
                    haveBest_d = 1'b1;
                    bestDist_d = selAcc;
                    mvX_d      = dx0Off_q + MV_W'(cnt_q) - MV_W'(RANGE);
                    mvY_d      = dyOff_q - MV_W'(RANGE);
                end
                if (cnt_q == LAST_LANE) begin
                    cnt_d = '0;
                    if (dx0Off_q == LAST_DX0) begin
                        dx0Off_d = '0;
                        if (dyOff_q == LAST_DY) begin
                            state_d = ST_DONE;
                        end else begin
                            dyOff_d = dyOff_q + MV_W'(1);
                            state_d = ST_RUN;
                        end
                    end else begin
                        dx0Off_d = dx0Off_q + MV_W'(NUM_PE);
                        state_d  = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + RA_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dyOff_q    <= '0;
            dx0Off_q   <= '0;
            pixValid_q <= 1'b0;
            pixFirst_q <= 1'b0;
            haveBest_q <= 1'b0;
            bestDist_q <= '1;
            mvX_q      <= '0;
            mvY_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dyOff_q    <= dyOff_d;
            dx0Off_q   <= dx0Off_d;
            pixValid_q <= pixValid_d;
            pixFirst_q <= pixFirst_d;
            haveBest_q <= haveBest_d;
            bestDist_q <= bestDist_d;
            mvX_q      <= mvX_d;
            mvY_q      <= mvY_d;
        end
    end

    assign best_dist = bestDist_q;
    assign mv_x      = mvX_q;
    assign mv_y      = mvY_q;

endmodule

// File: tb/tb_motion_search.sv
// Directed bench for motion_search: offset-copy match, tie-break, saturation,
// start handling and mid-search reset, with a small pixel memory model.
module tb_motion_search;

    localparam int SEARCH_LAT = 64 * (256 + 2 + 4) + 1;
    localparam int LIMIT      = 20000;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        busy, done, ref_rd, srch_rd;
    logic [7:0]  ref_addr;
    logic [9:0]  srch_addr;
    logic [7:0]  refData;
    logic [31:0] srchData;
    logic [15:0] best_dist;
    logic [3:0]  mv_x, mv_y;

    logic        satBusy, satDone, satRefRd, satSrchRd;
    logic [7:0]  satRefAddr;
    logic [9:0]  satSrchAddr;
    logic [7:0]  satBest;
    logic [3:0]  satMvX, satMvY;
    logic [7:0]  satRefData;
    logic [31:0] satSrchData;

    logic [7:0]  refMem  [256];
    logic [7:0]  srchMem [1024];

    int total;
    int bad;
    int lat;

    assign satRefData  = 8'd0;
    assign satSrchData = 32'hFFFF_FFFF;

    motion_search u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .ref_rd    (ref_rd),
        .ref_addr  (ref_addr),
        .ref_data  (refData),
        .srch_rd   (srch_rd),
        .srch_addr (srch_addr),
        .srch_data (srchData),
        .best_dist (best_dist),
        .mv_x      (mv_x),
        .mv_y      (mv_y)
    );

    motion_search #(.DIST_W(8)) u_dut_sat (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .busy      (satBusy),
        .done      (satDone),
        .ref_rd    (satRefRd),
        .ref_addr  (satRefAddr),
        .ref_data  (satRefData),
        .srch_rd   (satSrchRd),
        .srch_addr (satSrchAddr),
        .srch_data (satSrchData),
        .best_dist (satBest),
        .mv_x      (satMvX),
        .mv_y      (satMvY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ref_rd) begin
            refData <= refMem[ref_addr];
        end
        if (srch_rd) begin
            for (int k = 0; k < 4; k++) begin
                srchData[k*8 +: 8] <= srchMem[int'(srch_addr) + k];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Pattern 0: reference copied at (+3,-5). Pattern 1: horizontally periodic
    // reference copied at (-2,+1) and (+4,+1). Background is 255 elsewhere.
    task automatic applyStimulus(input int pattern);
        for (int i = 0; i < 1024; i++) srchMem[i] = 8'hFF;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                if (pattern == 0) begin
                    refMem[r*16+c] = 8'((r*16 + c) * 37 % 200);
                    srchMem[(r+3)*32 + c + 11] = refMem[r*16+c];
                end else begin
                    refMem[r*16+c] = 8'((r*17 + (c % 6)*29 + 5) % 200);
                    srchMem[(r+9)*32 + c + 6]  = refMem[r*16+c];
                    srchMem[(r+9)*32 + c + 12] = refMem[r*16+c];
                end
            end
        end
    endtask

    task automatic stepTo(inout int cnt, input int target);
        while (cnt < target) begin
            @(posedge clock);
            cnt++;
            #1;
        end
    endtask

    task automatic waitDone(inout int cnt);
        while (done !== 1'b1 && cnt < LIMIT) begin
            @(posedge clock);
            cnt++;
            #1;
        end
        checkOutput("done_seen", done, 1'b1);
    endtask

    task automatic checkLatency(input string tag, input int cnt);
`ifdef ME_EARLY_TERM_EN
        checkOutput(tag, cnt < SEARCH_LAT, 1'b1);
`else
        checkOutput(tag, cnt, SEARCH_LAT);
`endif
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        refData  = '0;
        srchData = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_strobes", {ref_rd, srch_rd}, 2'b00);
        checkOutput("rst_addr", {ref_addr, srch_addr}, 18'h0);
        checkOutput("rst_best", best_dist, 16'hFFFF);
        checkOutput("rst_mv", {mv_x, mv_y}, 8'h00);
        checkOutput("rst_sat_best", satBest, 8'hFF);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Offset-copy search with address spot checks and a start pulse while busy.
        applyStimulus(0);
        start = 1'b1;
        lat   = 0;
        stepTo(lat, 1);
        start = 1'b0;
        checkOutput("busy_run", busy, 1'b1);
        checkOutput("run0_strobes", {ref_rd, srch_rd}, 2'b11);
        checkOutput("run0_ref_addr", ref_addr, 8'd0);
        checkOutput("run0_srch_addr", srch_addr, 10'd0);
        stepTo(lat, 2);
        checkOutput("run1_srch_addr", srch_addr, 10'd1);
        stepTo(lat, 18);
        checkOutput("run17_ref_addr", ref_addr, 8'd17);
        checkOutput("run17_srch_addr", srch_addr, 10'd33);
        stepTo(lat, 29);
        start = 1'b1;
        stepTo(lat, 30);
        start = 1'b0;
        stepTo(lat, 257);
        checkOutput("drain_strobes", {ref_rd, srch_rd}, 2'b00);
        stepTo(lat, 263);
        checkOutput("grp1_ref_addr", ref_addr, 8'd0);
        checkOutput("grp1_srch_addr", srch_addr, 10'd4);
        waitDone(lat);
        checkLatency("latency_a", lat);
        checkOutput("a_best", best_dist, 16'd0);
        checkOutput("a_mv_x", mv_x, 4'h3);
        checkOutput("a_mv_y", mv_y, 4'hB);
        checkOutput("sat_done", satDone, 1'b1);
        checkOutput("sat_best", satBest, 8'hFF);
        checkOutput("sat_mv", {satMvX, satMvY}, 8'h88);
        @(posedge clock);
        #1;
        checkOutput("a_done_pulse", done, 1'b0);
        checkOutput("a_idle", busy, 1'b0);
        checkOutput("a_hold_best", best_dist, 16'd0);

        // Two exact matches in one row; start stays high through DONE.
        applyStimulus(1);
        start = 1'b1;
        lat   = 0;
        stepTo(lat, 1);
        waitDone(lat);
        checkLatency("latency_b", lat);
        checkOutput("b_best", best_dist, 16'd0);
        checkOutput("b_mv_x", mv_x, 4'hE);
        checkOutput("b_mv_y", mv_y, 4'h1);
        @(posedge clock);
        #1;
        checkOutput("b_idle_gap", busy, 1'b0);
        @(posedge clock);
        #1;
        checkOutput("b_restart_busy", busy, 1'b1);
        checkOutput("b_restart_rd", ref_rd, 1'b1);
        checkOutput("b_restart_best", best_dist, 16'hFFFF);
        checkOutput("b_restart_mv", {mv_x, mv_y}, 8'h00);

        // Reset in the middle of RUN, then a clean search.
        start = 1'b0;
        repeat (40) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_strobes", {ref_rd, srch_rd}, 2'b00);
        checkOutput("mid_rst_addr", {ref_addr, srch_addr}, 18'h0);
        checkOutput("mid_rst_best", best_dist, 16'hFFFF);
        checkOutput("mid_rst_mv", {mv_x, mv_y}, 8'h00);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("post_rst_idle", busy, 1'b0);
        applyStimulus(0);
        start = 1'b1;
        lat   = 0;
        stepTo(lat, 1);
        start = 1'b0;
        waitDone(lat);
        checkLatency("latency_c", lat);
        checkOutput("c_best", best_dist, 16'd0);
        checkOutput("c_mv_x", mv_x, 4'h3);
        checkOutput("c_mv_y", mv_y, 4'hB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
